// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - byte-wide IMEM port sequencer shared by fetch unit and program loader
// Loader has priority in IDLE; fetches assemble four big-endian byte reads into one instruction.
module imem_fetch_ctrl #(
   parameter int unsigned IMEM_SIZE = 4096,
   parameter int unsigned ADDR_W    = 64
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              fetch_valid_i,
   input  logic [ADDR_W-1:0] fetch_addr_i,
   output logic              fetch_ready_o,
   input  logic              flush_i,
   output logic [31:0]       instr_o,
   output logic              instr_valid_o,
   input  logic              instr_ready_i,
   output logic              fetch_err_o,
   input  logic              ld_valid_i,
   input  logic [ADDR_W-1:0] ld_addr_i,
   input  logic [7:0]        ld_data_i,
   output logic              ld_ready_o,
   output logic              ld_err_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              mem_we_o,
   output logic [7:0]        mem_wdata_o,
   input  logic [7:0]        mem_rdata_i
);

   localparam logic [ADDR_W-1:0] SIZE    = ADDR_W'(IMEM_SIZE);
   localparam logic [ADDR_W-1:0] LAST_OK = ADDR_W'(IMEM_SIZE - 4);

   typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

   state_t            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [2:0]        cnt_nxt;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [23:0]       shreg_q, shreg_d;
   logic [31:0]       instr_q, instr_d;
   logic              instr_valid_q, instr_valid_d;
   logic              fetch_err_q, fetch_err_d;
   logic              ld_err_q, ld_err_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_we_q, mem_we_d;
   logic [7:0]        mem_wdata_q, mem_wdata_d;
   logic              ld_acc, fetch_acc;

   // Readies are held low while reset is asserted so nothing is handshaken during reset.
   assign ld_ready_o    = rst_ni && (state_q == IDLE);
   assign fetch_ready_o = rst_ni && (state_q == IDLE) && !ld_valid_i && !flush_i;
   assign ld_acc        = ld_valid_i && ld_ready_o;
   assign fetch_acc     = fetch_valid_i && fetch_ready_o;
   assign cnt_nxt       = cnt_q + 3'd1;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      base_d        = base_q;
      shreg_d       = shreg_q;
      instr_d       = instr_q;
      instr_valid_d = instr_valid_q;
      fetch_err_d   = fetch_err_q;
      ld_err_d      = 1'b0;
      mem_addr_d    = mem_addr_q;
      mem_we_d      = 1'b0;
      mem_wdata_d   = mem_wdata_q;
      case (state_q)
         IDLE: begin
            if (ld_acc) begin
               if (ld_addr_i < SIZE) begin
                  state_d     = WRITE;
                  mem_we_d    = 1'b1;
                  mem_addr_d  = ld_addr_i;
                  mem_wdata_d = ld_data_i;
               end else begin
                  ld_err_d = 1'b1;
               end
            end else if (fetch_acc) begin
               if ((fetch_addr_i[1:0] != 2'b00) || (fetch_addr_i > LAST_OK)) begin
                  state_d       = RESP;
                  fetch_err_d   = 1'b1;
                  instr_d       = 32'h0;
                  instr_valid_d = 1'b1;
               end else begin
                  state_d    = READ;
                  base_d     = fetch_addr_i;
                  mem_addr_d = fetch_addr_i;
                  cnt_d      = 3'd0;
               end
            end
         end
         WRITE: state_d = IDLE;
         READ: begin
            // cnt_q counts READ cycles; the byte for address k arrives when cnt_q == k+1.
            if (flush_i) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_nxt;
               if (cnt_q < 3'd3) begin
                  mem_addr_d = base_q + ADDR_W'(cnt_nxt);
               end
               if (cnt_q == 3'd4) begin
                  instr_d       = {shreg_q, mem_rdata_i};
                  fetch_err_d   = 1'b0;
                  instr_valid_d = 1'b1;
                  state_d       = RESP;
               end else if (cnt_q != 3'd0) begin
                  shreg_d = {shreg_q[15:0], mem_rdata_i};
               end
            end
         end
         RESP: begin
            if (flush_i || instr_ready_i) begin
               instr_valid_d = 1'b0;
               state_d       = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         cnt_q         <= 3'd0;
         base_q        <= '0;
         shreg_q       <= 24'h0;
         instr_q       <= 32'h0;
         instr_valid_q <= 1'b0;
         fetch_err_q   <= 1'b0;
         ld_err_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_we_q      <= 1'b0;
         mem_wdata_q   <= 8'h0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         base_q        <= base_d;
         shreg_q       <= shreg_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         fetch_err_q   <= fetch_err_d;
         ld_err_q      <= ld_err_d;
         mem_addr_q    <= mem_addr_d;
         mem_we_q      <= mem_we_d;
         mem_wdata_q   <= mem_wdata_d;
      end
   end

   assign instr_o       = instr_q;
   assign instr_valid_o = instr_valid_q;
   assign fetch_err_o   = fetch_err_q;
   assign ld_err_o      = ld_err_q;
   assign mem_addr_o    = mem_addr_q;
   assign mem_we_o      = mem_we_q;
   assign mem_wdata_o   = mem_wdata_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - scoreboard bench for imem_fetch_ctrl with a byte-wide memory model
// Stimulus pushes expected responses; a negedge monitor pops them on each instr handshake.
module tb_imem_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_valid, fetch_ready, flush;
   logic [63:0] fetch_addr;
   logic [31:0] instr;
   logic        instr_valid, instr_ready, fetch_err;
   logic        ld_valid, ld_ready, ld_err;
   logic [63:0] ld_addr;
   logic [7:0]  ld_data;
   logic [63:0] mem_addr;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata = 8'h00;
   logic [7:0]  mem [4096];

   typedef struct packed {
      logic [31:0] instr;
      logic        err;
   } resp_t;
   resp_t sb[$];

   int nvec = 0;
   int nbad = 0;
   int we_cnt = 0;
   int ld_err_cnt = 0;

   always #5 clk = ~clk;

   imem_fetch_ctrl #(.IMEM_SIZE(4096), .ADDR_W(64)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .fetch_valid_i(fetch_valid), .fetch_addr_i(fetch_addr), .fetch_ready_o(fetch_ready),
      .flush_i(flush),
      .instr_o(instr), .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
      .fetch_err_o(fetch_err),
      .ld_valid_i(ld_valid), .ld_addr_i(ld_addr), .ld_data_i(ld_data),
      .ld_ready_o(ld_ready), .ld_err_o(ld_err),
      .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
      .mem_rdata_i(mem_rdata)
   );

   always @(posedge clk) begin
      if (mem_we && mem_addr < 64'd4096) mem[mem_addr[11:0]] <= mem_wdata;
      mem_rdata <= (mem_addr < 64'd4096) ? mem[mem_addr[11:0]] : 8'h00;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && mem_we) we_cnt++;
      if (rst_n && ld_err) ld_err_cnt++;
      if (rst_n && instr_valid && instr_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_resp", 64'(instr), 64'hDEAD);
         end else begin
            resp_t e;
            e = sb.pop_front();
            chk("resp_instr", 64'(instr), 64'(e.instr));
            chk("resp_err", 64'(fetch_err), 64'(e.err));
         end
      end
   end

   task automatic load(input logic [63:0] a, input logic [7:0] d);
      bit ok = 0;
      @(posedge clk); #1;
      ld_valid = 1'b1; ld_addr = a; ld_data = d;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ld_ready) begin ok = 1; break; end
      end
      if (!ok) chk("ld_accept_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      ld_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic fetch(input logic [63:0] a, input bit push, input logic [31:0] ei, input logic ee);
      bit ok = 0;
      @(posedge clk); #1;
      fetch_valid = 1'b1; fetch_addr = a;
      if (push) sb.push_back('{instr: ei, err: ee});
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (fetch_ready) begin ok = 1; break; end
      end
      if (!ok) chk("fetch_accept_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      fetch_valid = 1'b0;
   endtask

   // Called in the first cycle after accept; lat is the cycle index where instr_valid rises.
   task automatic wait_resp(input bit chk_addr, input logic [63:0] base, output int lat);
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (chk_addr && k <= 4) chk("rd_addr", mem_addr, base + 64'(k - 1));
         if (instr_valid) begin lat = k; break; end
      end
      @(posedge clk); #1;
   endtask

   task automatic expect_quiet(input string name, input int n);
      bit seen = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (instr_valid) seen = 1;
      end
      chk(name, 64'(seen), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int lat, w0, e0;
      for (int i = 0; i < 4096; i++) mem[i] = 8'(i) ^ 8'h5A;
      rst_n = 1'b0; fetch_valid = 1'b0; fetch_addr = '0; flush = 1'b0; instr_ready = 1'b1;
      ld_valid = 1'b0; ld_addr = '0; ld_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_instr_valid", 64'(instr_valid), 64'd0);
      chk("rst_mem_we", 64'(mem_we), 64'd0);
      chk("rst_mem_addr", mem_addr, 64'd0);
      chk("rst_ld_ready", 64'(ld_ready), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_ld_ready", 64'(ld_ready), 64'd1);
      chk("idle_fetch_ready", 64'(fetch_ready), 64'd1);

      // load then fetch
      w0 = we_cnt;
      load(64'd0, 8'h00); load(64'd1, 8'hA0); load(64'd2, 8'h00); load(64'd3, 8'h93);
      chk("t2_we_pulses", 64'(we_cnt - w0), 64'd4);
      chk("t2_ld_err", 64'(ld_err_cnt), 64'd0);
      fetch(64'd0, 1, 32'h00A00093, 1'b0);
      wait_resp(1, 64'd0, lat);
      chk("t2_latency", 64'(lat), 64'd6);

      // reset mid-READ
      fetch(64'd0, 0, 32'h0, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("t1_instr", 64'(instr), 64'd0);
      chk("t1_mem_addr", mem_addr, 64'd0);
      chk("t1_fetch_err", 64'(fetch_err), 64'd0);
      chk("t1_ld_err", 64'(ld_err), 64'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("t1_idle_ld_ready", 64'(ld_ready), 64'd1);
      expect_quiet("t1_no_resp", 8);

      // errors
      w0 = we_cnt;
      fetch(64'd2, 1, 32'h0, 1'b1);
      wait_resp(0, 64'd0, lat);
      chk("t4_misalign_lat", 64'(lat), 64'd1);
      chk("t4_misalign_noaccess", mem_addr, 64'd0);
      fetch(64'd4093, 1, 32'h0, 1'b1);
      wait_resp(0, 64'd0, lat);
      chk("t4_4093_lat", 64'(lat), 64'd1);
      fetch(64'd4096, 1, 32'h0, 1'b1);
      wait_resp(0, 64'd0, lat);
      chk("t4_4096_lat", 64'(lat), 64'd1);
      fetch(64'd4092, 1, 32'hA6A7A4A5, 1'b0);
      wait_resp(1, 64'd4092, lat);
      chk("t4_4092_lat", 64'(lat), 64'd6);
      e0 = ld_err_cnt;
      load(64'd4096, 8'hEE);
      @(posedge clk); #1;
      chk("t4_ld_err_pulse", 64'(ld_err_cnt - e0), 64'd1);
      chk("t4_no_write", 64'(we_cnt - w0), 64'd0);

      // arbitration
      load(64'd4, 8'h11); load(64'd5, 8'h22); load(64'd6, 8'h33); load(64'd7, 8'h44);
      @(posedge clk); #1;
      ld_valid = 1'b1; ld_addr = 64'd4; ld_data = 8'h55;
      fetch_valid = 1'b1; fetch_addr = 64'd4;
      sb.push_back('{instr: 32'h55223344, err: 1'b0});
      @(negedge clk);
      chk("t3_ld_ready", 64'(ld_ready), 64'd1);
      chk("t3_fetch_ready", 64'(fetch_ready), 64'd0);
      @(posedge clk); #1;
      ld_valid = 1'b0;
      @(negedge clk);
      chk("t3_write_fetch_ready", 64'(fetch_ready), 64'd0);
      chk("t3_write_we", 64'(mem_we), 64'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t3_after_fetch_ready", 64'(fetch_ready), 64'd1);
      @(posedge clk); #1;
      fetch_valid = 1'b0;
      wait_resp(1, 64'd4, lat);
      chk("t3_latency", 64'(lat), 64'd6);

      // flush in READ
      fetch(64'd0, 0, 32'h0, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      chk("t5_idle_after_flush", 64'(fetch_ready), 64'd1);
      expect_quiet("t5_read_flush_quiet", 8);
      // flush blocks fetch in IDLE
      @(posedge clk); #1;
      flush = 1'b1; fetch_valid = 1'b1; fetch_addr = 64'd0;
      @(negedge clk);
      chk("t5_flush_blocks", 64'(fetch_ready), 64'd0);
      @(posedge clk); #1;
      flush = 1'b0; fetch_valid = 1'b0;
      @(negedge clk);
      chk("t5_not_accepted", 64'(fetch_ready), 64'd1);
      // flush in RESP
      instr_ready = 1'b0;
      fetch(64'd0, 0, 32'h0, 1'b0);
      wait_resp(0, 64'd0, lat);
      chk("t5_resp_lat", 64'(lat), 64'd6);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      chk("t5_resp_dropped", 64'(instr_valid), 64'd0);
      chk("t5_resp_idle", 64'(fetch_ready), 64'd1);

      // backpressure
      fetch(64'd4, 1, 32'h55223344, 1'b0);
      wait_resp(0, 64'd0, lat);
      chk("t6_lat", 64'(lat), 64'd6);
      ld_valid = 1'b1; ld_addr = 64'd8; ld_data = 8'h77;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t6_valid_held", 64'(instr_valid), 64'd1);
         chk("t6_instr_held", 64'(instr), 64'h55223344);
         chk("t6_ld_blocked", 64'(ld_ready), 64'd0);
         @(posedge clk); #1;
      end
      instr_ready = 1'b1;
      @(negedge clk);
      chk("t6_ld_blocked_last", 64'(ld_ready), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t6_valid_cleared", 64'(instr_valid), 64'd0);
      chk("t6_instr_retained", 64'(instr), 64'h55223344);
      chk("t6_ld_ready", 64'(ld_ready), 64'd1);
      @(posedge clk); #1;
      ld_valid = 1'b0;
      @(posedge clk); #1;
      fetch(64'd8, 1, 32'h77535051, 1'b0);
      wait_resp(1, 64'd8, lat);
      chk("t6_ld_fetch_lat", 64'(lat), 64'd6);

      repeat (3) @(posedge clk);
      #1;
      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
